key_filter_multi: RTL



---
 rtl/key_filter_multi.sv | 135 +++++++++++++
 1 files changed

// File: rtl/key_filter_multi.sv
// key_filter_multi: multi-channel push-button debouncer.
// Each channel synchronises its raw pin, accepts a level change only after
// DEB_CYCLES consecutive differing samples, and emits registered one-cycle
// press, release and long-press pulses alongside the debounced level.
module key_filter_multi #(
  parameter int N_KEYS      = 4,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_stable,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  // Last value of each counter before it acts.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  // Pin level of a released key; the synchronisers start here so reset
  // never looks like a press.
  localparam logic [N_KEYS-1:0] IDLE_PINS = {N_KEYS{ACTIVE_LOW}};

  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] state_q, state_d;
  logic [N_KEYS-1:0] long_done_q, long_done_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] long_q, long_d;
  logic [DW-1:0]     deb_cnt_q  [N_KEYS];
  logic [DW-1:0]     deb_cnt_d  [N_KEYS];
  logic [HW-1:0]     hold_cnt_q [N_KEYS];
  logic [HW-1:0]     hold_cnt_d [N_KEYS];

  logic [N_KEYS-1:0] sample;   // normalised: 1 = pressed
  logic [N_KEYS-1:0] differ;   // sample disagrees with accepted level
  logic [N_KEYS-1:0] accept;   // this edge completes a full differing run

  assign sample = sync2_q ^ IDLE_PINS;
  assign differ = sample ^ state_q;

  // Flag channels whose differing run reaches DEB_CYCLES on this edge.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    accept = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      accept[i] = differ[i] && (deb_cnt_q[i] == DEB_LAST);
    end
  end

  // Next-state logic: synchroniser shift, debounce run, hold timer, pulses.
  always_comb begin
    sync1_d     = key;
    sync2_d     = sync1_q;
    state_d     = state_q;
    long_done_d = long_done_q;
    press_d     = '0;
    release_d   = '0;
    long_d      = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      deb_cnt_d[i]  = deb_cnt_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];

      if (!differ[i]) begin
        // One agreeing sample cancels the whole run.
        deb_cnt_d[i] = '0;
      end else if (!accept[i]) begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end

      if (accept[i]) begin
        // Acceptance in either direction restarts the hold timer; a release
        // landing on the long-press edge wins, so pulses never overlap.
        state_d[i]     = sample[i];
        deb_cnt_d[i]   = '0;
        press_d[i]     = sample[i];
        release_d[i]   = ~sample[i];
        hold_cnt_d[i]  = '0;
        long_done_d[i] = 1'b0;
      end else if (state_q[i] && !long_done_q[i]) begin
        // Count held cycles; freeze after the single long pulse.
        hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
        if (hold_cnt_q[i] == HOLD_LAST) begin
          long_d[i]      = 1'b1;
          long_done_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q     <= IDLE_PINS;
      sync2_q     <= IDLE_PINS;
      state_q     <= '0;
      long_done_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      // NOTE: the counter arrays are real per-channel registers, not RAM, so they are reset explicitly.
      for (int i = 0; i < N_KEYS; i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      long_done_q <= long_done_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      for (int i = 0; i < N_KEYS; i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign key_stable  = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule
